rr_arbiter_8: RTL
=================

Name: rr_arbiter_8

Overview:
- 8-way round-robin arbiter for a shared single-user resource.
- Encodes the winning requester to a 3-bit index, then drives a registered one-hot grant, i.e. a 3x8 decode of that index.
- Sits between eight requesting blocks and the resource. Grant is held until the owner signals done, drops its request, or exceeds a hold limit.
- Guarantees one dead cycle between consecutive owners.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT cycles for one owner. Must be >= 1.
- CNT_W, 5, hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i = requester i
- done  input  1  current owner finished; sampled only in GRANT
- grant  output  8  registered one-hot grant; all zero when no owner
- grant_idx  output  3  binary index of the current owner; holds the last owner when idle
- grant_valid  output  1  high exactly when grant != 0
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- One clock; reset is synchronous and active-high. Reset is sampled on the rising edge of clk and overrides all other inputs.
- Reset values:
  - grant = 8'h00, grant_idx = 3'd0, grant_valid = 0, timeout = 0.
  - Priority pointer ptr = 3'd0, hold counter = 0, state = IDLE.
- States: IDLE, GRANT, GAP. All outputs are registered.
- IDLE:
  - If req == 0, stay in IDLE with grant = 0.
  - Otherwise the winner w is the first set bit of req, searching ptr, ptr+1, ..., 7, 0, ..., ptr-1, with wrap-around modulo 8.
  - On that edge: grant <= 1<<w, grant_idx <= w, grant_valid <= 1, counter <= 1, state <= GRANT.
  - Latency: req high before edge k gives grant visible after edge k.
- GRANT: the revoke condition is evaluated each edge, in this priority order:
  1. req[grant_idx] == 0 (request withdrawn).
  2. done == 1.
  3. counter == MAX_HOLD (timeout; timeout <= 1 for exactly one cycle).
  - On revoke: grant <= 0, grant_valid <= 0, ptr <= grant_idx+1 (mod 8), state <= GAP.
  - Otherwise: counter <= counter+1, and grant holds.
  - With MAX_HOLD = N, an owner that never releases sees grant high for exactly N cycles.
  - Simultaneous done and timeout: treat as a normal release, so timeout stays 0.
- GAP:
  - Exactly one cycle with grant = 0, unconditionally; state <= IDLE.
  - Requests present during GAP are arbitrated on the next edge, from IDLE.
- Fairness: the previous owner has the lowest priority in the next arbitration. With all 8 requesting continuously, grants rotate 0,1,...,7,0.
- Requests from non-owners arriving during GRANT never preempt the owner.
- Reset mid-grant: grant drops after the reset edge and ptr returns to 0.
- Invariants checked by the bench:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - When grant_valid = 1, grant == 1<<grant_idx.
  - Two different owners are never granted on adjacent cycles.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> grant=8'h00, grant_valid=0, grant_idx=0, timeout=0 throughout.
- req=8'h04 held, done pulsed on the 3rd GRANT cycle -> grant=8'h04 and grant_idx=2 for 3 cycles, one GAP cycle of 0, then grant=8'h04 again (sole requester).
- req=8'hFF held, done pulsed every GRANT cycle -> owner sequence 0,1,2,...,7,0 with a zero grant cycle between each. Also checks the 7->0 wrap.
- MAX_HOLD=4, req=8'h20 held, done=0 -> grant=8'h20 for exactly 4 cycles, timeout=1 on the revoke cycle, GAP, then re-grant to 5.
- Owner 3 granted, req changes 8'h08 -> 8'h90 (owner drops, 4 and 7 request) -> revoke, GAP, next grant=8'h10 (4 follows ptr=4), not 8'h80.
- Assert rst while grant=8'h40 -> grant=8'h00 after that edge. With req=8'h41 held, the first grant after rst releases is 8'h01.

Source files
------------

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between eight requesters and the arbiter.
// master: requester side (drives req/done); slave: arbiter side.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with hold limit and one dead cycle between owners.
// Ports: clk, rst (sync, active-high); bus (slave): req/done in, grant/idx/valid/timeout out.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input logic            clk,
  input logic            rst,
  rr_arbiter_8_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;

  logic [2:0]       win;
  logic             hit;

  // Rotating priority search: scan from ptr upward with wrap.
  // Iterating from the far end lets the closest hit win.
  always_comb begin
    logic [2:0] cand;
    cand = '0;
    win  = ptr_q;
    hit  = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (bus.req[cand]) begin
        win = cand;
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    tout_d  = 1'b0;
    unique case (state_q)
      GRANT: begin
        if (!bus.req[idx_q] || bus.done ||
            cnt_q == CNT_W'(MAX_HOLD)) begin
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = idx_q + 3'd1;
          state_d = GAP;
          // Release (withdraw or done) wins over the hold limit.
          tout_d  = bus.req[idx_q] && !bus.done;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // GAP is the single dead cycle; the edge leaving it
      // already arbitrates, so the next owner follows directly.
      IDLE, GAP: begin
        state_d = IDLE;
        if (hit) begin
          grant_d = 8'(1) << win;
          idx_d   = win;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = GRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = tout_q;

endmodule
